msgdma_st_packetizer: RTL and testbench



---
 rtl/msgdma_pkg.sv | 17 +
 rtl/msgdma_pkt_fifo.sv | 54 +++++
 rtl/msgdma_st_packetizer.sv | 143 ++++++++++++++
 tb/tb_msgdma_st_packetizer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msgdma_pkg.sv
// Shared types for the mSGDMA streaming packetizer: FSM states, entry tags, counter widths.
package msgdma_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PAD  = 1'b1
    } state_e;

    localparam int PKT_CNT_W = 16;
    localparam int IDX_W     = 16;

    typedef struct packed {
        logic sop;
        logic eop;
    } tag_t;

endpackage

// File: rtl/msgdma_pkt_fifo.sv
// Synchronous show-ahead FIFO; a push is refused when the registered level is full,
// even if a pop happens in the same cycle.
module msgdma_pkt_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/msgdma_st_packetizer.sv
// Frames sample strobes into fixed-length Avalon-ST packets with padded flush.
// Optional idle auto-flush enabled by defining MSGDMA_PKT_TIMEOUT_EN.
//
//   state   | meaning
//   ST_FILL | accepting samples, tagging sop/eop by write index
//   ST_PAD  | writing PAD_VALUE until the eop entry of the partial packet is written
module msgdma_st_packetizer
    import msgdma_pkg::*;
#(
    parameter int             N          = 32,
    parameter int             PKT_LEN    = 16,
    parameter int             FIFO_DEPTH = 32,
    parameter logic [N-1:0]   PAD_VALUE  = '0,
    parameter int             TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_valid,
    input  logic [N-1:0]                  data,
    input  logic                          flush,
    input  logic                          clr_overflow,
    output logic [N-1:0]                  src_data,
    output logic                          src_valid,
    input  logic                          src_ready,
    output logic                          src_sop,
    output logic                          src_eop,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [PKT_CNT_W-1:0]          pkt_count
);
    typedef struct packed {
        tag_t           tag;
        logic [N-1:0]   data;
    } entry_t;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       idx_next;
    logic                   idx_last;
    logic                   overflow_q;
    logic [PKT_CNT_W-1:0]   pkt_cnt_q;
    logic                   push, pop, drop;
    logic                   flush_req;
    logic                   fifo_full, fifo_empty;
    entry_t                 wr_entry, rd_entry;

    assign idx_last = (idx_q == IDX_W'(PKT_LEN - 1));
    assign idx_next = idx_last ? '0 : idx_q + 1'b1;

    assign wr_entry.tag.sop = (idx_q == '0);
    assign wr_entry.tag.eop = idx_last;
    assign wr_entry.data    = (state_q == ST_PAD) ? PAD_VALUE : data;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        push    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                if (data_valid) begin
                    if (fifo_full) begin
                        drop = 1'b1;
                    end else begin
                        push  = 1'b1;
                        idx_d = idx_next;
                    end
                end
                // A sample completing the packet this cycle leaves nothing to pad.
                if (flush_req && (idx_d != '0)) state_d = ST_PAD;
            end
            ST_PAD: begin
                drop = data_valid;
                if (!fifo_full) begin
                    push  = 1'b1;
                    idx_d = idx_next;
                    if (idx_last) state_d = ST_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FILL;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (drop)              overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
            if (pop && rd_entry.tag.eop) pkt_cnt_q <= pkt_cnt_q + 1'b1;
        end
    end

`ifdef MSGDMA_PKT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    logic [TMO_W-1:0] idle_q;
    logic             tmo_hit;

    assign tmo_hit   = (state_q == ST_FILL) && (idx_q != '0) &&
                       (idle_q == TMO_W'(TIMEOUT - 1));
    assign flush_req = flush | tmo_hit;

    always_ff @(posedge clk) begin
        if (reset || push || flush || tmo_hit) begin
            idle_q <= '0;
        end else if ((state_q == ST_FILL) && (idx_q != '0)) begin
            idle_q <= idle_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign flush_req      = flush;
`endif

    msgdma_pkt_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fill_level)
    );

    assign pop       = ~fifo_empty & src_ready;
    assign src_valid = ~fifo_empty;
    assign src_data  = src_valid ? rd_entry.data    : '0;
    assign src_sop   = src_valid & rd_entry.tag.sop;
    assign src_eop   = src_valid & rd_entry.tag.eop;
    assign overflow  = overflow_q;
    assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_msgdma_st_packetizer.sv
// Directed self-checking bench for msgdma_st_packetizer (PKT_LEN=4, FIFO_DEPTH=32).
module tb_msgdma_st_packetizer;
    localparam int N          = 32;
    localparam int PKT_LEN    = 4;
    localparam int FIFO_DEPTH = 32;
    localparam int TIMEOUT    = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           data_valid = 1'b0;
    logic [N-1:0]   data = '0;
    logic           flush = 1'b0;
    logic           clr_overflow = 1'b0;
    logic           src_ready = 1'b0;
    logic [N-1:0]   src_data;
    logic           src_valid, src_sop, src_eop, overflow;
    logic [5:0]     fill_level;
    logic [15:0]    pkt_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         sop;
        logic         eop;
        logic [N-1:0] d;
    } beat_t;
    beat_t got[$];

    always #5 clk = ~clk;

    msgdma_st_packetizer #(
        .N          (N),
        .PKT_LEN    (PKT_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PAD_VALUE  ('0),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_valid   (data_valid),
        .data         (data),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_sop      (src_sop),
        .src_eop      (src_eop),
        .overflow     (overflow),
        .fill_level   (fill_level),
        .pkt_count    (pkt_count)
    );

    // Record every beat that the next rising edge will accept.
    always @(negedge clk) begin
        if (!reset && src_valid && src_ready)
            got.push_back('{sop: src_sop, eop: src_eop, d: src_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", src_valid); end
        total++; if (src_sop !== 1'b0) begin bad++; $display("FAIL rst_sop got=%0b exp=0", src_sop); end
        total++; if (src_eop !== 1'b0) begin bad++; $display("FAIL rst_eop got=%0b exp=0", src_eop); end
        total++; if (src_data !== '0) begin bad++; $display("FAIL rst_data got=%0h exp=0", src_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0b exp=0", overflow); end
        total++; if (fill_level !== 6'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fill_level); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL rst_pktcnt got=%0d exp=0", pkt_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        got.delete();
        src_ready  = 1'b1;
        data_valid = 1'b1;
        data       = N'(1);
        tick();
        total++; if (src_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%0b exp=1", src_valid); end
        total++; if (src_data !== N'(1)) begin bad++; $display("FAIL lat_data got=%0h exp=1", src_data); end
        total++; if (src_sop !== 1'b1) begin bad++; $display("FAIL lat_sop got=%0b exp=1", src_sop); end
        for (int i = 2; i <= 8; i++) begin
            data = N'(i);
            tick();
        end
        data_valid = 1'b0;
        repeat (6) tick();
        total++; if (got.size() !== 8) begin bad++; $display("FAIL basic_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) begin
                total++; if (got[i].d !== N'(i + 1)) begin bad++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, got[i].d, i + 1); end
                total++; if (got[i].sop !== (i % 4 == 0)) begin bad++; $display("FAIL basic_sop[%0d] got=%0b", i, got[i].sop); end
                total++; if (got[i].eop !== (i % 4 == 3)) begin bad++; $display("FAIL basic_eop[%0d] got=%0b", i, got[i].eop); end
            end
        end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("FAIL basic_pktcnt got=%0d exp=2", pkt_count); end
    endtask

    task automatic test_overflow();
        int n;
        got.delete();
        src_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            data_valid = 1'b1;
            data       = N'(100 + i);
            tick();
        end
        data_valid = 1'b0;
        total++; if (fill_level !== 6'd32) begin bad++; $display("FAIL ovf_level got=%0d exp=32", fill_level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        total++; if (src_data !== N'(100)) begin bad++; $display("FAIL ovf_head got=%0d exp=100", src_data); end
        total++; if (src_sop !== 1'b1) begin bad++; $display("FAIL ovf_head_sop got=%0b exp=1", src_sop); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
        // Push while full with a same-cycle pop and clear: push refused, drop beats clear.
        data_valid   = 1'b1;
        data         = N'(999);
        clr_overflow = 1'b1;
        src_ready    = 1'b1;
        tick();
        data_valid   = 1'b0;
        clr_overflow = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_drop_wins got=%0b exp=1", overflow); end
        total++; if (fill_level !== 6'd31) begin bad++; $display("FAIL ovf_full_push got=%0d exp=31", fill_level); end
        n = 0;
        while (src_valid && n < 100) begin
            tick();
            n++;
        end
        total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain_timeout valid=%0b exp=0", src_valid); end
        total++; if (got.size() !== 32) begin bad++; $display("FAIL ovf_count got=%0d exp=32", got.size()); end
        for (int i = 0; i < 32; i++) begin
            if (i < got.size()) begin
                total++; if (got[i].d !== N'(100 + i)) begin bad++; $display("FAIL ovf_data[%0d] got=%0d exp=%0d", i, got[i].d, 100 + i); end
                total++; if (got[i].sop !== (i % 4 == 0)) begin bad++; $display("FAIL ovf_sop[%0d] got=%0b", i, got[i].sop); end
                total++; if (got[i].eop !== (i % 4 == 3)) begin bad++; $display("FAIL ovf_eop[%0d] got=%0b", i, got[i].eop); end
            end
        end
        total++; if (pkt_count !== 16'd10) begin bad++; $display("FAIL ovf_pktcnt got=%0d exp=10", pkt_count); end
    endtask

    task automatic test_flush();
        got.delete();
        src_ready  = 1'b1;
        data_valid = 1'b1;
        data = N'('hA); tick();
        data = N'('hB); tick();
        data = N'('hC); tick();
        data_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (8) tick();
        total++; if (got.size() !== 4) begin bad++; $display("FAIL flush_count got=%0d exp=4", got.size()); end
        if (got.size() == 4) begin
            total++; if (got[0].d !== N'('hA) || got[0].sop !== 1'b1) begin bad++; $display("FAIL flush_w0 got=%0h/%0b exp=a/1", got[0].d, got[0].sop); end
            total++; if (got[1].d !== N'('hB)) begin bad++; $display("FAIL flush_w1 got=%0h exp=b", got[1].d); end
            total++; if (got[2].d !== N'('hC) || got[2].eop !== 1'b0) begin bad++; $display("FAIL flush_w2 got=%0h/%0b exp=c/0", got[2].d, got[2].eop); end
            total++; if (got[3].d !== N'(0) || got[3].eop !== 1'b1) begin bad++; $display("FAIL flush_pad got=%0h/%0b exp=0/1", got[3].d, got[3].eop); end
        end
        total++; if (pkt_count !== 16'd11) begin bad++; $display("FAIL flush_pktcnt got=%0d exp=11", pkt_count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        total++; if (got.size() !== 4) begin bad++; $display("FAIL flush_idle_count got=%0d exp=4", got.size()); end
        total++; if (fill_level !== 6'd0) begin bad++; $display("FAIL flush_idle_level got=%0d exp=0", fill_level); end
        total++; if (pkt_count !== 16'd11) begin bad++; $display("FAIL flush_idle_pktcnt got=%0d exp=11", pkt_count); end
    endtask

    task automatic test_backpressure();
        logic         held_v;
        logic [N-1:0] held_d;
        logic         held_s, held_e;
        int           stab;
        got.delete();
        src_ready  = 1'b0;
        data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = N'('h50 + i);
            tick();
        end
        data_valid = 1'b0;
        held_v = 1'b0;
        held_d = '0;
        held_s = 1'b0;
        held_e = 1'b0;
        stab   = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            src_ready = (c % 2 == 0);
            @(negedge clk);
            if (held_v) begin
                stab++;
                total++; if (src_data !== held_d) begin bad++; $display("FAIL bp_stable_data got=%0h exp=%0h", src_data, held_d); end
                total++; if (src_sop !== held_s) begin bad++; $display("FAIL bp_stable_sop got=%0b exp=%0b", src_sop, held_s); end
                total++; if (src_eop !== held_e) begin bad++; $display("FAIL bp_stable_eop got=%0b exp=%0b", src_eop, held_e); end
            end
            held_v = src_valid && !src_ready;
            held_d = src_data;
            held_s = src_sop;
            held_e = src_eop;
        end
        src_ready = 1'b1;
        repeat (3) tick();
        total++; if (stab < 3) begin bad++; $display("FAIL bp_holds got=%0d exp>=3", stab); end
        total++; if (got.size() !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                total++; if (got[i].d !== N'('h50 + i)) begin bad++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", i, got[i].d, 'h50 + i); end
                total++; if (got[i].sop !== (i == 0) || got[i].eop !== (i == 3)) begin bad++; $display("FAIL bp_tags[%0d] got=%0b%0b", i, got[i].sop, got[i].eop); end
            end
        end
        total++; if (pkt_count !== 16'd12) begin bad++; $display("FAIL bp_pktcnt got=%0d exp=12", pkt_count); end
    endtask

    task automatic test_reset_mid();
        got.delete();
        src_ready  = 1'b0;
        data_valid = 1'b1;
        data = N'('h60); tick();
        data = N'('h61); tick();
        data_valid = 1'b0;
        total++; if (fill_level !== 6'd2) begin bad++; $display("FAIL rmid_pre_level got=%0d exp=2", fill_level); end
        reset = 1'b1;
        tick();
        total++; if (src_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b exp=0", src_valid); end
        total++; if (src_sop !== 1'b0 || src_eop !== 1'b0) begin bad++; $display("FAIL rmid_tags got=%0b%0b exp=00", src_sop, src_eop); end
        total++; if (src_data !== '0) begin bad++; $display("FAIL rmid_data got=%0h exp=0", src_data); end
        total++; if (fill_level !== 6'd0) begin bad++; $display("FAIL rmid_level got=%0d exp=0", fill_level); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL rmid_pktcnt got=%0d exp=0", pkt_count); end
        reset      = 1'b0;
        src_ready  = 1'b1;
        data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = N'('h70 + i);
            tick();
        end
        data_valid = 1'b0;
        repeat (5) tick();
        total++; if (got.size() !== 4) begin bad++; $display("FAIL rmid_count got=%0d exp=4", got.size()); end
        if (got.size() == 4) begin
            total++; if (got[0].d !== N'('h70) || got[0].sop !== 1'b1) begin bad++; $display("FAIL rmid_first got=%0h/%0b exp=70/1", got[0].d, got[0].sop); end
            total++; if (got[3].d !== N'('h73) || got[3].eop !== 1'b1) begin bad++; $display("FAIL rmid_last got=%0h/%0b exp=73/1", got[3].d, got[3].eop); end
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL rmid_post_pktcnt got=%0d exp=1", pkt_count); end
    endtask

`ifdef MSGDMA_PKT_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        got.delete();
        src_ready  = 1'b1;
        data_valid = 1'b1;
        data       = N'('hEE);
        tick();
        data_valid = 1'b0;
        n = 0;
        while (got.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++; if (got.size() < 2) begin bad++; $display("FAIL tmo_no_pad got=%0d exp>=2", got.size()); end
        total++; if (n < 16 || n > 20) begin bad++; $display("FAIL tmo_delay got=%0d exp=16..20", n); end
        repeat (6) tick();
        total++; if (got.size() !== 4) begin bad++; $display("FAIL tmo_count got=%0d exp=4", got.size()); end
        if (got.size() == 4) begin
            total++; if (got[0].d !== N'('hEE) || got[0].sop !== 1'b1) begin bad++; $display("FAIL tmo_first got=%0h/%0b exp=ee/1", got[0].d, got[0].sop); end
            total++; if (got[1].d !== '0 || got[2].d !== '0 || got[3].d !== '0) begin bad++; $display("FAIL tmo_pad got=%0h %0h %0h exp=0", got[1].d, got[2].d, got[3].d); end
            total++; if (got[3].eop !== 1'b1) begin bad++; $display("FAIL tmo_eop got=%0b exp=1", got[3].eop); end
        end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("FAIL tmo_pktcnt got=%0d exp=2", pkt_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_flush();
        test_backpressure();
        test_reset_mid();
`ifdef MSGDMA_PKT_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
